// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types, opcodes and helpers for the ALU command sequencer.
// Command entries are packed {op, b, a} so one FIFO word holds a whole operation.
package alu_cmd_sequencer_pkg;

  localparam int DATA_W   = 8;
  localparam int RES_W    = 16;
  localparam int OP_WIDTH = 4;
  localparam int CMD_W    = OP_WIDTH + 2 * DATA_W;

  localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_WIDTH-1:0] OP_MUL  = 4'b0010;
  localparam logic [OP_WIDTH-1:0] OP_DIV  = 4'b0011;
  localparam logic [OP_WIDTH-1:0] OP_MOD  = 4'b0100;
  localparam logic [OP_WIDTH-1:0] OP_SHL  = 4'b0101;
  localparam logic [OP_WIDTH-1:0] OP_ROL  = 4'b0110;
  localparam logic [OP_WIDTH-1:0] OP_ROR  = 4'b0111;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 4'b1000;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 4'b1001;
  localparam logic [OP_WIDTH-1:0] OP_NAND = 4'b1010;
  localparam logic [OP_WIDTH-1:0] OP_NOR  = 4'b1011;
  localparam logic [OP_WIDTH-1:0] OP_XOR  = 4'b1100;
  localparam logic [OP_WIDTH-1:0] OP_XNOR = 4'b1101;
  localparam logic [OP_WIDTH-1:0] OP_NOT  = 4'b1110;
  localparam logic [OP_WIDTH-1:0] OP_TWOS = 4'b1111;

  localparam logic [RES_W-1:0] DIV0_RESULT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [OP_WIDTH-1:0] op;
    logic [DATA_W-1:0]   b;
    logic [DATA_W-1:0]   a;
  } alu_cmd_t;

  // Only add, subtract and the rotates produce a meaningful extra bit.
  function automatic logic has_e_bit(input logic [OP_WIDTH-1:0] op);
    logic keep;
    case (op)
      OP_ADD, OP_SUB, OP_ROL, OP_ROR: keep = 1'b1;
      default:                        keep = 1'b0;
    endcase
    return keep;
  endfunction

  function automatic logic is_div_zero(input alu_cmd_t cmd);
    return (cmd.op == OP_DIV) && (cmd.b == {DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and response signals of the sequencer; slave = sequencer side,
// master = control/test side that also models the combinational ALU.
interface alu_cmd_sequencer_if;
  import alu_cmd_sequencer_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [DATA_W-1:0]   cmd_a;
  logic [DATA_W-1:0]   cmd_b;
  logic [OP_WIDTH-1:0] cmd_op;

  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [OP_WIDTH-1:0] alu_sel;
  logic [RES_W-1:0]    alu_result;
  logic                alu_e_bit;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [RES_W-1:0]    rsp_result;
  logic                rsp_e_bit;
  logic [OP_WIDTH-1:0] rsp_op;
  logic                rsp_err;
  logic                busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_e_bit, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_e_bit,
           rsp_op, rsp_err, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_e_bit, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_e_bit,
           rsp_op, rsp_err, busy
  );

endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// Command FIFO: DEPTH entries of {op, b, a}. can_push is registered so the
// upstream ready never combinationally depends on a same-cycle pop.
module alu_cmd_sequencer_fifo
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  alu_cmd_t wr_data,
  input  logic     pop,
  output alu_cmd_t rd_data,
  output logic     empty,
  output logic     empty_next,
  output logic     can_push
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  alu_cmd_t         mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;
  logic             can_push_r;
  logic             push_en_s;
  logic             pop_en_s;

  assign push_en_s = push & can_push_r;
  assign pop_en_s  = pop & (count_r != {CNT_W{1'b0}});

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_s = count_r;
    case ({push_en_s, pop_en_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      can_push_r <= 1'b0;
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r    <= count_s;
      can_push_r <= (count_s != CNT_W'(DEPTH));
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data    = mem_r[rd_ptr_r];
  assign empty      = (count_r == {CNT_W{1'b0}});
  assign empty_next = (count_s == {CNT_W{1'b0}});
  assign can_push   = can_push_r;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives buffered commands one at a time onto a combinational ALU and returns
// each captured result over a valid/ready response channel, in command order.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input logic           clk,
  input logic           rst,
  alu_cmd_sequencer_if.slave bus
);

  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  seq_state_e          state_r;
  seq_state_e          state_s;
  alu_cmd_t            head_s;
  alu_cmd_t            wr_cmd_s;
  logic                fifo_empty_s;
  logic                fifo_empty_next_s;
  logic                fifo_can_push_s;
  logic                push_s;
  logic                pop_s;
  logic                load_alu_s;
  logic                load_div0_s;
  logic                capture_s;
  logic                settle_done_s;
  logic [SETTLE_W-1:0] settle_cnt_r;

  logic [DATA_W-1:0]   alu_a_r;
  logic [DATA_W-1:0]   alu_b_r;
  logic [OP_WIDTH-1:0] alu_sel_r;
  logic                rsp_valid_r;
  logic [RES_W-1:0]    rsp_result_r;
  logic                rsp_e_bit_r;
  logic [OP_WIDTH-1:0] rsp_op_r;
  logic                rsp_err_r;
  logic                busy_r;

  assign wr_cmd_s      = {bus.cmd_op, bus.cmd_b, bus.cmd_a};
  assign push_s        = bus.cmd_valid & fifo_can_push_s;
  assign settle_done_s = (settle_cnt_r == SETTLE_W'(SETTLE - 1));

  alu_cmd_sequencer_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .wr_data   (wr_cmd_s),
    .pop       (pop_s),
    .rd_data   (head_s),
    .empty     (fifo_empty_s),
    .empty_next(fifo_empty_next_s),
    .can_push  (fifo_can_push_s)
  );

  // Next state: IDLE, or RESP once its response is taken, dispatches the FIFO head.
  always_comb begin
    state_s     = state_r;
    pop_s       = 1'b0;
    load_alu_s  = 1'b0;
    load_div0_s = 1'b0;
    capture_s   = 1'b0;
    if ((state_r == ST_IDLE) || ((state_r == ST_RESP) && bus.rsp_ready)) begin
      if (fifo_empty_s) begin
        state_s = ST_IDLE;
      end else begin
        pop_s = 1'b1;
        if (is_div_zero(head_s)) begin
          load_div0_s = 1'b1;
          state_s     = ST_RESP;
        end else begin
          load_alu_s = 1'b1;
          state_s    = ST_ISSUE;
        end
      end
    end else begin
      case (state_r)
        ST_ISSUE: begin
          if (settle_done_s) begin
            state_s = ST_CAPTURE;
          end else begin
            state_s = ST_ISSUE;
          end
        end
        ST_CAPTURE: begin
          capture_s = 1'b1;
          state_s   = ST_RESP;
        end
        ST_RESP: state_s = ST_RESP;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, settle counter and ALU operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= {SETTLE_W{1'b0}};
      alu_a_r      <= {DATA_W{1'b0}};
      alu_b_r      <= {DATA_W{1'b0}};
      alu_sel_r    <= {OP_WIDTH{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE) || !fifo_empty_next_s;
      if (load_alu_s) begin
        settle_cnt_r <= {SETTLE_W{1'b0}};
        alu_a_r      <= head_s.a;
        alu_b_r      <= head_s.b;
        alu_sel_r    <= head_s.op;
      end else if ((state_r == ST_ISSUE) && !settle_done_s) begin
        settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
      end
    end
  end

  // Response registers; divide-by-zero bypasses the ALU and leaves alu_* untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= {RES_W{1'b0}};
      rsp_e_bit_r  <= 1'b0;
      rsp_op_r     <= {OP_WIDTH{1'b0}};
      rsp_err_r    <= 1'b0;
    end else begin
      if (capture_s) begin
        rsp_valid_r  <= 1'b1;
        rsp_result_r <= bus.alu_result;
        rsp_e_bit_r  <= bus.alu_e_bit & has_e_bit(alu_sel_r);
        rsp_op_r     <= alu_sel_r;
        rsp_err_r    <= 1'b0;
      end else if (load_div0_s) begin
        rsp_valid_r  <= 1'b1;
        rsp_result_r <= DIV0_RESULT;
        rsp_e_bit_r  <= 1'b0;
        rsp_op_r     <= head_s.op;
        rsp_err_r    <= 1'b1;
      end else if ((state_r == ST_RESP) && bus.rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready  = fifo_can_push_s;
  assign bus.alu_a      = alu_a_r;
  assign bus.alu_b      = alu_b_r;
  assign bus.alu_sel    = alu_sel_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_e_bit  = rsp_e_bit_r;
  assign bus.rsp_op     = rsp_op_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.busy       = busy_r;

endmodule
